// File: rtl/fc_pkg.sv
// Shared types for the fully-connected layer datapath.
package fc_pkg;

    localparam int BitSizeDefault = 8;

    typedef logic [BitSizeDefault-1:0] fc_word_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DRAIN
    } skew_state_e;

endpackage

// File: rtl/skew_lane.sv
// One skew lane: a Depth-stage delay line carrying data plus a valid bit,
// with the output forced to zero whenever the last stage is invalid.
module skew_lane #(
    parameter int BitSize = 8,
    parameter int Depth   = 1
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               in_valid,
    input  logic [BitSize-1:0] in_data,
    output logic               out_valid,
    output logic [BitSize-1:0] out_data,
    output logic               any_valid
);

    logic [Depth-1:0]              vld;
    logic [Depth-1:0][BitSize-1:0] dat;

    always_ff @(posedge clk or posedge res_n) begin
        if (res_n) begin
            vld <= '0;
            dat <= '0;
        end else begin
            vld[0] <= in_valid;
            dat[0] <= in_valid ? in_data : '0;
            for (int i = 1; i < Depth; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[Depth-1];
    assign out_data  = vld[Depth-1] ? dat[Depth-1] : '0;
    assign any_valid = |vld;

endmodule

// File: rtl/fc_input_skewer.sv
// Re-times rows of A into the diagonal stream of the systolic array and
// regenerates start/valid/done framing aligned with the skewed data.
module fc_input_skewer
    import fc_pkg::*;
#(
    parameter int BitSize     = 8,
    parameter int NumOfInputs = 2
) (
    input  logic                                  clk,
    input  logic                                  res_n,
    input  logic                                  in_valid,
    input  logic                                  in_start,
    input  logic                                  in_last,
    input  logic [NumOfInputs-1:0][BitSize-1:0]   in_data,
    output logic                                  out_valid,
    output logic                                  out_start,
    output logic                                  out_done,
    output logic                                  out_busy,
    output logic [NumOfInputs-1:0][BitSize-1:0]   out_data
);

    logic [NumOfInputs-1:0] lane_valid;
    logic [NumOfInputs-1:0] lane_busy;
    logic [NumOfInputs-1:0] done_sr;
    logic [NumOfInputs-1:0] early_done;
    logic                   start_q;
    logic                   acc;
    logic                   acc_start;
    logic                   acc_last;

    skew_state_e state, state_next;
    logic        drain_new, drain_new_next;

    assign acc       = in_valid;
    assign acc_start = in_valid & in_start;
    assign acc_last  = in_valid & in_last;

    for (genvar k = 0; k < NumOfInputs; k++) begin : g_lane
        skew_lane #(
            .BitSize (BitSize),
            .Depth   (k + 1)
        ) u_lane (
            .clk       (clk),
            .res_n     (res_n),
            .in_valid  (in_valid),
            .in_data   (in_data[k]),
            .out_valid (lane_valid[k]),
            .out_data  (out_data[k]),
            .any_valid (lane_busy[k])
        );
    end

    // Each accepted last row gets its own done pulse, so overlapping matrices never merge.
    always_ff @(posedge clk or posedge res_n) begin
        if (res_n) begin
            start_q <= 1'b0;
            done_sr <= '0;
        end else begin
            start_q    <= acc_start;
            done_sr[0] <= acc_last;
            for (int i = 1; i < NumOfInputs; i++) begin
                done_sr[i] <= done_sr[i-1];
            end
        end
    end

    assign out_start = start_q;
    assign out_done  = done_sr[NumOfInputs-1];
    assign out_valid = |lane_valid;
    assign out_busy  = (|lane_busy) | (|done_sr);

    always_comb begin
        early_done                = done_sr;
        early_done[NumOfInputs-1] = 1'b0;
    end

    always_ff @(posedge clk or posedge res_n) begin
        if (res_n) begin
            state     <= IDLE;
            drain_new <= 1'b0;
        end else begin
            state     <= state_next;
            drain_new <= drain_new_next;
        end
    end

    // Draining ends only when the newest last row leaves and nothing younger is in flight.
    always_comb begin
        state_next     = state;
        drain_new_next = drain_new;
        case (state)
            IDLE: begin
                if (acc_last) begin
                    state_next     = DRAIN;
                    drain_new_next = 1'b0;
                end else if (acc) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (acc_last) begin
                    state_next     = DRAIN;
                    drain_new_next = 1'b0;
                end else if (lane_valid[NumOfInputs-1]) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (acc_last) begin
                    state_next     = DRAIN;
                    drain_new_next = 1'b0;
                end
            end
            DRAIN: begin
                if (acc_last) begin
                    drain_new_next = 1'b0;
                end else if (acc_start) begin
                    state_next = FILL;
                end else if (acc) begin
                    drain_new_next = 1'b1;
                end else if (out_done && !drain_new && (early_done == '0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    a_idle_quiet: assert property (@(posedge clk) disable iff (res_n)
        (state == IDLE) |-> !out_busy);

endmodule

// File: tb/tb_fc_input_skewer.sv
// Randomised scoreboard bench for fc_input_skewer against a row-history reference model.
module tb_fc_input_skewer;

    localparam int N = 4;
    localparam int W = 8;

    logic                 clk = 1'b0;
    logic                 res_n = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_start = 1'b0;
    logic                 in_last = 1'b0;
    logic [N-1:0][W-1:0]  in_data = '0;
    logic                 out_valid;
    logic                 out_start;
    logic                 out_done;
    logic                 out_busy;
    logic [N-1:0][W-1:0]  out_data;

    fc_input_skewer #(
        .BitSize     (W),
        .NumOfInputs (N)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .in_valid  (in_valid),
        .in_start  (in_start),
        .in_last   (in_last),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_start (out_start),
        .out_done  (out_done),
        .out_busy  (out_busy),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                v;
        logic                s;
        logic                l;
        logic [N-1:0][W-1:0] d;
    } row_t;

    typedef struct packed {
        logic [N-1:0][W-1:0] data;
        logic                valid;
        logic                start;
        logic                done;
        logic                busy;
    } exp_t;

    // hist[j] is the row presented j+1 cycles before the currently visible output
    row_t hist[$];
    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic exp_t model();
        exp_t e;
        e = '0;
        for (int k = 0; k < N; k++) begin
            if (hist[k].v) begin
                e.data[k] = hist[k].d[k];
                e.valid   = 1'b1;
            end
        end
        e.start = hist[0].v & hist[0].s;
        e.done  = hist[N-1].v & hist[N-1].l;
        for (int j = 0; j < N; j++) begin
            if (hist[j].v) e.busy = 1'b1;
        end
        return e;
    endfunction

    task automatic clearHistory();
        hist.delete();
        for (int j = 0; j < N; j++) hist.push_back('0);
    endtask

    task automatic compareField(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("out_data",  64'(out_data),  64'(e.data));
        compareField("out_valid", 64'(out_valid), 64'(e.valid));
        compareField("out_start", 64'(out_start), 64'(e.start));
        compareField("out_done",  64'(out_done),  64'(e.done));
        compareField("out_busy",  64'(out_busy),  64'(e.busy));
    endtask

    // One cycle: record what the DUT sampled at the edge, optionally reset, queue expectation, drive next row
    task automatic applyStimulus(input logic v, input logic s, input logic l,
                                 input logic [N-1:0][W-1:0] d,
                                 input bit rst_assert = 0, input bit rst_release = 0);
        row_t r;
        @(posedge clk);
        #1;
        r.v = in_valid;
        r.s = in_start;
        r.l = in_last;
        r.d = in_data;
        if (res_n) r = '0;
        hist.push_front(r);
        void'(hist.pop_back());
        if (rst_assert) begin
            res_n = 1'b1;
            clearHistory();
        end
        if (rst_release) res_n = 1'b0;
        exp_q.push_back(model());
        in_valid = v;
        in_start = s;
        in_last  = l;
        in_data  = d;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic sendMatrix(input bit bubble);
        logic [N-1:0][W-1:0] row;
        for (int r = 0; r < 4; r++) begin
            if (bubble && r == 2) applyStimulus(1'b0, 1'b0, 1'b0, '0);
            for (int c = 0; c < N; c++) row[c] = W'(16 * r + c);
            applyStimulus(1'b1, r == 0, r == 3, row);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        logic [N-1:0][W-1:0] row;
        clearHistory();
        $display("[TB] reset and idle");
        idle(3);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 0, 1);
        idle(2);

        $display("[TB] 4x4 matrix back to back");
        sendMatrix(0);
        idle(8);

        $display("[TB] matrix with a bubble");
        sendMatrix(1);
        idle(8);

        $display("[TB] two matrices back to back");
        sendMatrix(0);
        sendMatrix(0);
        idle(8);

        $display("[TB] single-row matrix");
        row = {8'd8, 8'd7, 8'd6, 8'd5};
        applyStimulus(1'b1, 1'b1, 1'b1, row);
        idle(6);

        $display("[TB] reset mid-matrix");
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < N; c++) row[c] = W'(16 * r + c + 1);
            applyStimulus(1'b1, r == 0, 1'b0, row);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 0, 1);
        idle(6);

        $display("[TB] start/last without valid");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, {$urandom()});
        idle(6);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                applyStimulus(1'b0, 1'b0, 1'b0, '0, 1, 0);
                applyStimulus(1'b0, 1'b0, 1'b0, '0, 0, 1);
            end else begin
                applyStimulus($urandom_range(0, 9) < 7,
                              $urandom_range(0, 7) == 0,
                              $urandom_range(0, 5) == 0,
                              {$urandom()});
            end
        end
        idle(8);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
